// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory bus arbiter.
package mem_arb_pkg;

  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RESP     = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  // Fields latched at grant and held for the life of the transaction.
  typedef struct packed {
    owner_e      owner;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and downstream memory signals of the arbiter.
// slave = arbiter side, master = requesters plus memory environment.
interface mem_bus_arbiter_if;
  logic        instruction_valid;
  logic [31:0] instruction_addr;
  logic        instruction_ready;
  logic        instruction_ack;
  logic [31:0] instruction_read;

  logic        data_read_valid;
  logic        data_write_valid;
  logic [31:0] data_addr;
  logic [31:0] data_write;
  logic [3:0]  data_write_byte;
  logic        data_ready;
  logic        data_ack;
  logic [31:0] data_read;

  logic        mem_valid;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  instruction_valid, instruction_addr,
    output instruction_ready, instruction_ack, instruction_read,
    input  data_read_valid, data_write_valid, data_addr, data_write, data_write_byte,
    output data_ready, data_ack, data_read,
    output mem_valid, mem_addr, mem_we, mem_wdata, mem_be,
    input  mem_ready, mem_ack, mem_rdata
  );

  modport master (
    output instruction_valid, instruction_addr,
    input  instruction_ready, instruction_ack, instruction_read,
    output data_read_valid, data_write_valid, data_addr, data_write, data_write_byte,
    input  data_ready, data_ack, data_read,
    input  mem_valid, mem_addr, mem_we, mem_wdata, mem_be,
    output mem_ready, mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_arb_select.sv
// Grant selection: data wins unless the fetch side has been passed over
// STARVE_LIMIT times in a row while waiting.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   instr_valid_i,
  input  logic   data_valid_i,
  input  logic   grant_en_i,
  output logic   grant_o,
  output owner_e owner_o
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;

  // Winner selection from the pending requests and the starvation count.
  always_comb begin
    grant_o = grant_en_i & (instr_valid_i | data_valid_i);
    if (data_valid_i && !(instr_valid_i && starve_q == LIMIT)) owner_o = OWN_DATA;
    else                                                      owner_o = OWN_INSTR;
  end

  // Count data grants made over a waiting fetch; saturate, clear on fetch grant.
  always_comb begin
    starve_d = starve_q;
    if (grant_o) begin
      if (owner_o == OWN_INSTR)                      starve_d = '0;
      else if (instr_valid_i && starve_q != LIMIT)   starve_d = starve_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) starve_q <= '0;
    else          starve_q <= starve_d;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single-outstanding memory port.
// A grant may be taken from IDLE or from the RESP cycle, so back-to-back
// traffic issues once every two cycles; with nothing pending RESP returns
// to IDLE.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input logic             clk,
  input logic             reset_n,
  mem_bus_arbiter_if.slave bus
);

  arb_state_e  state_q, state_d;
  txn_t        txn_q, txn_d;
  logic        iready_q, iready_d, dready_q, dready_d;
  logic [31:0] iread_q, iread_d, dread_q, dread_d;

  logic   grant_en, grant, capture, data_valid;
  owner_e owner;

  assign data_valid = bus.data_read_valid | bus.data_write_valid;
  assign grant_en   = (state_q == ST_IDLE) || (state_q == ST_RESP);

  mem_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .clk           (clk),
    .reset_n       (reset_n),
    .instr_valid_i (bus.instruction_valid),
    .data_valid_i  (data_valid),
    .grant_en_i    (grant_en),
    .grant_o       (grant),
    .owner_o       (owner)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state; mem_ack is only honoured while a request is outstanding.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RESP: state_d = grant ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:         if (bus.mem_ready) state_d = bus.mem_ack ? ST_RESP : ST_WAIT_ACK;
      ST_WAIT_ACK:      if (bus.mem_ack)   state_d = ST_RESP;
      default:          state_d = ST_IDLE;
    endcase
  end

  assign capture = (state_q != ST_RESP) && (state_d == ST_RESP);

  // Datapath next values: latch the winner at grant, capture read data on completion.
  always_comb begin
    txn_d    = txn_q;
    iready_d = 1'b0;
    dready_d = 1'b0;
    iread_d  = iread_q;
    dread_d  = dread_q;
    if (grant) begin
      txn_d.owner = owner;
      if (owner == OWN_DATA) begin
        // Both valids set is a store; wdata is zeroed for reads.
        txn_d.addr  = bus.data_addr;
        txn_d.we    = bus.data_write_valid;
        txn_d.be    = bus.data_write_byte;
        txn_d.wdata = bus.data_write_valid ? bus.data_write : '0;
        dready_d    = 1'b1;
      end else begin
        txn_d.addr  = bus.instruction_addr;
        txn_d.we    = 1'b0;
        txn_d.be    = 4'hF;
        txn_d.wdata = '0;
        iready_d    = 1'b1;
      end
    end
    if (capture) begin
      if (txn_q.owner == OWN_INSTR) iread_d = bus.mem_rdata;
      else                          dread_d = txn_q.we ? '0 : bus.mem_rdata;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txn_q    <= '0;
      iready_q <= 1'b0;
      dready_q <= 1'b0;
      iread_q  <= '0;
      dread_q  <= '0;
    end else begin
      txn_q    <= txn_d;
      iready_q <= iready_d;
      dready_q <= dready_d;
      iread_q  <= iread_d;
      dread_q  <= dread_d;
    end
  end

  // Outputs decoded from state and held registers.
  always_comb begin
    bus.instruction_ready = iready_q;
    bus.data_ready        = dready_q;
    bus.instruction_ack   = (state_q == ST_RESP) && (txn_q.owner == OWN_INSTR);
    bus.data_ack          = (state_q == ST_RESP) && (txn_q.owner == OWN_DATA);
    bus.instruction_read  = iread_q;
    bus.data_read         = dread_q;
    bus.mem_valid         = (state_q == ST_ISSUE);
    bus.mem_addr          = txn_q.addr;
    bus.mem_we            = txn_q.we;
    bus.mem_wdata         = txn_q.wdata;
    bus.mem_be            = txn_q.be;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level reference: one in-flight request, described by whether
  // it still awaits memory acceptance or completion.
  int          m_cnt;
  bit          m_pending, m_waiting, m_owner_data, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  bit          exp_iready, exp_dready, exp_iack, exp_dack;
  logic [31:0] exp_iread, exp_dread;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pending = 0; m_waiting = 0; m_owner_data = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_be = '0;
    exp_iready = 0; exp_dready = 0; exp_iack = 0; exp_dack = 0;
    exp_iread = '0; exp_dread = '0;
  endtask

  // Advance the reference over one clock edge using the inputs held before it.
  task automatic model_edge();
    bit can_grant, done, iv, dv, pick_data;
    logic [31:0] cap;
    can_grant = !m_pending && !m_waiting;
    done = 0;
    cap  = '0;
    exp_iready = 0; exp_dready = 0;
    if (m_pending && bus.mem_ready) begin
      m_pending = 0;
      if (bus.mem_ack) begin done = 1; cap = bus.mem_rdata; end
      else m_waiting = 1;
    end else if (m_waiting && bus.mem_ack) begin
      m_waiting = 0; done = 1; cap = bus.mem_rdata;
    end
    exp_iack = done && !m_owner_data;
    exp_dack = done && m_owner_data;
    if (done) begin
      if (m_owner_data) exp_dread = m_we ? 32'h0 : cap;
      else              exp_iread = cap;
    end
    iv = bus.instruction_valid;
    dv = bus.data_read_valid || bus.data_write_valid;
    if (can_grant && (iv || dv)) begin
      pick_data = dv && !(iv && m_cnt == LIMIT);
      m_pending = 1;
      if (pick_data) begin
        m_owner_data = 1;
        m_addr  = bus.data_addr;
        m_we    = bus.data_write_valid;
        m_be    = bus.data_write_byte;
        m_wdata = bus.data_write_valid ? bus.data_write : 32'h0;
        exp_dready = 1;
        if (iv && m_cnt < LIMIT) m_cnt++;
      end else begin
        m_owner_data = 0;
        m_addr = bus.instruction_addr; m_we = 0; m_be = 4'hF; m_wdata = 32'h0;
        exp_iready = 1;
        m_cnt = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("instruction_ready", 32'(bus.instruction_ready), 32'(exp_iready));
    check("data_ready",        32'(bus.data_ready),        32'(exp_dready));
    check("instruction_ack",   32'(bus.instruction_ack),   32'(exp_iack));
    check("data_ack",          32'(bus.data_ack),          32'(exp_dack));
    check("instruction_read",  bus.instruction_read,       exp_iread);
    check("data_read",         bus.data_read,              exp_dread);
    check("mem_valid",         32'(bus.mem_valid),         32'(m_pending));
    check("mem_addr",          bus.mem_addr,               m_addr);
    check("mem_we",            32'(bus.mem_we),            32'(m_we));
    check("mem_wdata",         bus.mem_wdata,              m_wdata);
    check("mem_be",            32'(bus.mem_be),            32'(m_be));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (reset_n) model_edge();
    compare_all();
  endtask

  task automatic idle_inputs();
    bus.instruction_valid = 0; bus.data_read_valid = 0; bus.data_write_valid = 0;
    bus.mem_ready = 0; bus.mem_ack = 0;
  endtask

  byte   grants[10];
  int    n_g;
  string exp_seq = "DDDDIDDDDI";

  initial begin
    idle_inputs();
    bus.instruction_addr = '0; bus.data_addr = '0; bus.data_write = '0;
    bus.data_write_byte = '0; bus.mem_rdata = '0;
    #2;
    model_reset();
    compare_all();
    step(); step();
    reset_n = 1;

    // Single fetch, immediate memory.
    bus.instruction_valid = 1; bus.instruction_addr = 32'h100;
    bus.mem_ready = 1; bus.mem_ack = 1; bus.mem_rdata = 32'h13;
    step();
    check("fetch_ready_n1", 32'(bus.instruction_ready), 32'h1);
    check("fetch_mem_addr", bus.mem_addr, 32'h100);
    check("fetch_mem_be",   32'(bus.mem_be), 32'hF);
    bus.instruction_valid = 0;
    step();
    check("fetch_ack_n2",  32'(bus.instruction_ack), 32'h1);
    check("fetch_read",    bus.instruction_read, 32'h13);
    idle_inputs();
    step();

    // Store with memory acceptance delayed three cycles.
    bus.data_write_valid = 1; bus.data_addr = 32'h2000;
    bus.data_write = 32'hDEADBEEF; bus.data_write_byte = 4'b0011;
    step();
    check("store_ready", 32'(bus.data_ready), 32'h1);
    bus.data_write_valid = 0; bus.data_addr = 32'hFFFF_FFFF;
    bus.data_write = 32'h0; bus.data_write_byte = 4'hF;
    for (int i = 0; i < 4; i++) begin
      check("store_hold_valid", 32'(bus.mem_valid), 32'h1);
      check("store_hold_addr",  bus.mem_addr, 32'h2000);
      check("store_hold_wdata", bus.mem_wdata, 32'hDEADBEEF);
      check("store_hold_be",    32'(bus.mem_be), 32'h3);
      check("store_hold_we",    32'(bus.mem_we), 32'h1);
      if (i == 3) bus.mem_ready = 1;
      step();
    end
    check("store_wait_valid", 32'(bus.mem_valid), 32'h0);
    bus.mem_ready = 0; bus.mem_ack = 1; bus.mem_rdata = 32'h1234_5678;
    step();
    check("store_ack",  32'(bus.data_ack), 32'h1);
    check("store_read", bus.data_read, 32'h0);
    idle_inputs();
    step();

    // Load and store both set -> store.
    bus.data_read_valid = 1; bus.data_write_valid = 1; bus.data_addr = 32'h3000;
    bus.data_write = 32'hA5A5A5A5; bus.data_write_byte = 4'b1100;
    bus.mem_ready = 1; bus.mem_ack = 1; bus.mem_rdata = 32'h77;
    step();
    check("both_we",    32'(bus.mem_we), 32'h1);
    check("both_wdata", bus.mem_wdata, 32'hA5A5A5A5);
    bus.data_read_valid = 0; bus.data_write_valid = 0;
    step();
    check("both_ack",  32'(bus.data_ack), 32'h1);
    check("both_read", bus.data_read, 32'h0);
    idle_inputs();
    step();

    // Fetch and load continuously pending: starvation pattern.
    bus.instruction_valid = 1; bus.instruction_addr = 32'h400;
    bus.data_read_valid = 1; bus.data_addr = 32'h500; bus.data_write_byte = 4'hF;
    bus.mem_ready = 1; bus.mem_ack = 1; bus.mem_rdata = 32'h42;
    n_g = 0;
    for (int i = 0; i < 10; i++) grants[i] = "-";
    for (int c = 0; c < 20; c++) begin
      step();
      if (n_g < 10 && (bus.data_ready || bus.instruction_ready)) begin
        grants[n_g] = (bus.data_ready && bus.instruction_ready) ? "X" :
                      (bus.data_ready ? "D" : "I");
        n_g++;
      end
    end
    for (int i = 0; i < 10; i++) check("starve_seq", 32'(grants[i]), 32'(exp_seq[i]));
    idle_inputs();
    step(); step();

    // Reset during WAIT_ACK, then a stray ack.
    bus.data_read_valid = 1; bus.data_addr = 32'h600; bus.data_write_byte = 4'hF;
    step();
    bus.data_read_valid = 0; bus.mem_ready = 1;
    step();
    bus.mem_ready = 0;
    step();
    check("rst_pre_wait", 32'(bus.mem_valid), 32'h0);
    reset_n = 0;
    #1;
    model_reset();
    compare_all();
    check("rst_valid", 32'(bus.mem_valid), 32'h0);
    check("rst_iread", bus.instruction_read, 32'h0);
    step();
    reset_n = 1;
    bus.mem_ack = 1; bus.mem_rdata = 32'hBAD;
    step();
    check("stray_dack", 32'(bus.data_ack), 32'h0);
    check("stray_read", bus.data_read, 32'h0);
    bus.mem_ack = 0;
    bus.instruction_valid = 1; bus.instruction_addr = 32'h700;
    bus.mem_ready = 1; bus.mem_ack = 1; bus.mem_rdata = 32'h99;
    step();
    check("post_rst_iready", 32'(bus.instruction_ready), 32'h1);
    bus.instruction_valid = 0;
    step();
    check("post_rst_iack", 32'(bus.instruction_ack), 32'h1);
    check("post_rst_read", bus.instruction_read, 32'h99);
    idle_inputs();
    step();

    // Randomized traffic against the reference.
    for (int c = 0; c < 3000; c++) begin
      if (!bus.instruction_valid || exp_iready) begin
        bus.instruction_valid = ($urandom_range(0, 2) != 0);
        bus.instruction_addr  = $urandom;
      end
      if (!(bus.data_read_valid || bus.data_write_valid) || exp_dready) begin
        int kind;
        kind = $urandom_range(0, 3);
        bus.data_read_valid  = (kind == 1) || (kind == 3);
        bus.data_write_valid = (kind == 2) || (kind == 3);
        bus.data_addr        = $urandom;
        bus.data_write       = $urandom;
        bus.data_write_byte  = 4'($urandom_range(0, 15));
      end
      bus.mem_ready = ($urandom_range(0, 1) != 0);
      bus.mem_ack   = ($urandom_range(0, 2) == 0);
      bus.mem_rdata = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 0;
        #1;
        model_reset();
        compare_all();
      end else begin
        reset_n = 1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
